// File: rtl/ga_pkg.sv
// Shared definitions for the GA network blocks: RAM opcodes, phase encodings,
// DNA geometry helpers and the loader FSM state type.
package ga_pkg;

   localparam int ADDR_W = 23;
   localparam int GENE_W = 16;
   localparam int IDX_W  = 8;

   localparam logic OP_READ  = 1'b0;
   localparam logic OP_WRITE = 1'b1;

   localparam logic [1:0] NS_INIT   = 2'd0;
   localparam logic [1:0] NS_LOAD   = 2'd1;
   localparam logic [1:0] NS_EVAL   = 2'd2;
   localparam logic [1:0] NS_EVOLVE = 2'd3;

   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      WAIT_BUSY,
      WAIT_DATA,
      PRESENT
   } state_t;

   // Words per network: one per output plus one per neuron input.
   function automatic int genes(input int outputs, input int neurons, input int connections);
      return outputs + neurons * connections;
   endfunction

   // First illegal gene value; anything at or above it cannot name a source.
   function automatic int gene_limit(input int outputs, input int neurons);
      return outputs + neurons + 1;
   endfunction

endpackage

// File: rtl/dna_loader_if.sv
// Gene stream from the loader to the network evaluator (valid/ready).
interface dna_loader_if;
   import ga_pkg::*;

   logic              geneValid;
   logic              geneReady;
   logic [GENE_W-1:0] geneData;
   logic [IDX_W-1:0]  geneIndex;

   modport master (output geneValid, output geneData, output geneIndex, input geneReady);
   modport slave  (input geneValid, input geneData, input geneIndex, output geneReady);
endinterface

// File: rtl/ram_read_port.sv
// Single-word read over the shared RAM bus: latch strobe, wait for the
// controller to go busy, then take data when it reports ready again.
module ram_read_port
   import ga_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              own,
   input  logic              req,
   input  logic [ADDR_W-1:0] addr,
   output logic              rd_valid,
   output logic [GENE_W-1:0] rd_data,
   input  logic              ramReady,
   input  logic [GENE_W-1:0] ramBusDataOut,
   inout  wire  [ADDR_W-1:0] ramBusAddr,
   inout  wire               ramLatch,
   inout  wire               ramInstruction
);

   state_t            state, state_n;
   logic [ADDR_W-1:0] addr_q;
   logic              latch;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_n;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                    addr_q <= '0;
      else if (state == IDLE && req) addr_q <= addr;
   end

   always_comb begin
      state_n = state;
      if (!own) state_n = IDLE;
      else begin
         case (state)
            IDLE:      if (req)       state_n = ISSUE;
            ISSUE:     if (ramReady)  state_n = WAIT_BUSY;
            WAIT_BUSY: if (!ramReady) state_n = WAIT_DATA;
            WAIT_DATA: if (ramReady)  state_n = IDLE;
            default:                  state_n = IDLE;
         endcase
      end
   end

   // The strobe is only ever high in the single ISSUE cycle the controller is idle.
   always_comb begin
      latch    = (state == ISSUE) && ramReady;
      rd_valid = own && (state == WAIT_DATA) && ramReady;
      rd_data  = ramBusDataOut;
   end

   assign ramBusAddr     = own ? addr_q  : {ADDR_W{1'bz}};
   assign ramLatch       = own ? latch   : 1'bz;
   assign ramInstruction = own ? OP_READ : 1'bz;

endmodule

// File: rtl/dna_loader.sv
// Fetches the gene words of one network from RAM and streams them, in address
// order, to the network evaluator.
module dna_loader
   import ga_pkg::*;
#(
   parameter int         INPUT_COUNT             = 1,
   parameter int         OUTPUT_COUNT            = 1,
   parameter int         NEURON_COUNT            = 2,
   parameter int         CONNECTIONS             = 2,
   parameter int         NETWORKS_PER_POPULATION = 16,
   parameter logic [1:0] LOAD_STATE              = NS_LOAD
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [1:0]        networkState,
   input  logic              start,
   input  logic [IDX_W-1:0]  netIndex,
   output logic              busy,
   output logic              done,
   output logic              error,
   dna_loader_if.master      gene,
   inout  wire  [ADDR_W-1:0] ramBusAddr,
   inout  wire               ramLatch,
   inout  wire               ramInstruction,
   input  logic              ramReady,
   input  logic [GENE_W-1:0] ramBusDataOut
);

   localparam int GENES      = genes(OUTPUT_COUNT, NEURON_COUNT, CONNECTIONS);
   localparam int GENE_LIMIT = gene_limit(OUTPUT_COUNT, NEURON_COUNT);
   localparam logic [IDX_W-1:0] LAST_G = IDX_W'(GENES - 1);
   // A misconfigured instance rejects every load with error rather than reading garbage.
   localparam bit CFG_OK = (INPUT_COUNT >= 1) && (OUTPUT_COUNT >= 1) && (NEURON_COUNT >= 1)
                           && (GENES <= (1 << IDX_W));

   state_t            state, state_n;
   logic              own, idx_ok, start_ok, accept, last, req;
   logic [IDX_W-1:0]  g;
   logic [ADDR_W-1:0] addr_q, req_addr;
   logic              rd_valid;
   logic [GENE_W-1:0] rd_data;

   assign own      = (networkState == LOAD_STATE);
   assign idx_ok   = CFG_OK && (int'(netIndex) < NETWORKS_PER_POPULATION);
   assign start_ok = start && own && idx_ok;
   assign last     = (g == LAST_G);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_n;
   end

   // Leaving the load phase drops everything; the bus is already released combinationally.
   always_comb begin
      state_n = state;
      if (!own) state_n = IDLE;
      else begin
         case (state)
            IDLE:    if (start_ok)        state_n = ISSUE;
            ISSUE:   if (rd_valid)        state_n = PRESENT;
            PRESENT: if (gene.geneReady)  state_n = last ? IDLE : ISSUE;
            default:                      state_n = IDLE;
         endcase
      end
   end

   always_comb begin
      busy           = (state != IDLE);
      gene.geneValid = (state == PRESENT);
      accept         = own && (state == PRESENT) && gene.geneReady;
      req            = ((state == IDLE) && start_ok) || (accept && !last);
      req_addr       = (state == IDLE) ? ADDR_W'(netIndex) * ADDR_W'(GENES) + ADDR_W'(1)
                                       : addr_q + ADDR_W'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         g              <= '0;
         addr_q         <= '0;
         done           <= 1'b0;
         error          <= 1'b0;
         gene.geneData  <= '0;
         gene.geneIndex <= '0;
      end else begin
         done  <= accept && last;
         error <= ((state == IDLE) && start && own && !idx_ok)
               || ((state == ISSUE) && rd_valid && (rd_data >= GENE_W'(GENE_LIMIT)));
         if (req) begin
            addr_q <= req_addr;
            g      <= (state == IDLE) ? '0 : g + IDX_W'(1);
         end
         if ((state == ISSUE) && rd_valid) begin
            gene.geneData  <= rd_data;
            gene.geneIndex <= g;
         end
      end
   end

   ram_read_port u_rd (
      .clk            (clk),
      .rst_n          (rst_n),
      .own            (own),
      .req            (req),
      .addr           (req_addr),
      .rd_valid       (rd_valid),
      .rd_data        (rd_data),
      .ramReady       (ramReady),
      .ramBusDataOut  (ramBusDataOut),
      .ramBusAddr     (ramBusAddr),
      .ramLatch       (ramLatch),
      .ramInstruction (ramInstruction)
   );

endmodule

// File: tb/tb_dna_loader.sv
// Directed bench for dna_loader: RAM model on the shared bus, scoreboard of
// expected genes, immediate assertions at every comparison.
module tb_dna_loader;
   import ga_pkg::*;

   typedef struct {
      logic [22:0] addr;
      logic [15:0] data;
      logic [7:0]  idx;
      logic        err;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [1:0]  networkState;
   logic        start;
   logic [7:0]  netIndex;
   logic        busy, done, error;
   wire  [22:0] ramBusAddr;
   wire         ramLatch, ramInstruction;
   logic        ramReady = 1'b1;
   logic [15:0] ramBusDataOut = '0;

   dna_loader_if gif ();

   pullup (ramLatch);
   pullup (ramInstruction);

   dna_loader dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .networkState   (networkState),
      .start          (start),
      .netIndex       (netIndex),
      .busy           (busy),
      .done           (done),
      .error          (error),
      .gene           (gif),
      .ramBusAddr     (ramBusAddr),
      .ramLatch       (ramLatch),
      .ramInstruction (ramInstruction),
      .ramReady       (ramReady),
      .ramBusDataOut  (ramBusDataOut)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;
   exp_t sbq[$];

   // RAM model: contents selectable between addr=data and addr[1:0]
   bit          ram_mode = 1'b0;
   int          ram_lat = 0;
   bit          pend = 1'b0;
   int          lat_cnt = 0;
   logic [22:0] cap_addr = '0;
   logic [22:0] lat_log [256];
   int          lat_total = 0;
   int          width_err = 0;
   bit          prev_hi = 1'b0;
   wire         lat_hi = (networkState == NS_LOAD) && (ramLatch === 1'b1);

   function automatic logic [15:0] ram_data(input logic [22:0] a);
      return ram_mode ? {14'b0, a[1:0]} : a[15:0];
   endfunction

   always @(posedge clk) begin
      if (lat_hi && prev_hi) width_err <= width_err + 1;
      prev_hi <= lat_hi;
      if (pend) begin
         if (lat_cnt > 0) lat_cnt <= lat_cnt - 1;
         else begin
            pend          <= 1'b0;
            ramReady      <= 1'b1;
            ramBusDataOut <= ram_data(cap_addr);
         end
      end else if (lat_hi && ramReady) begin
         cap_addr  <= ramBusAddr;
         pend      <= 1'b1;
         ramReady  <= 1'b0;
         lat_cnt   <= ram_lat;
         if (lat_total < 256) lat_log[lat_total] <= ramBusAddr;
         lat_total <= lat_total + 1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   // Full load of one network; expectations are queued before start is driven.
   task automatic do_load(input logic [7:0] net, input int stall_gene, input int stall_cyc,
                          input bit b2b, input int exp_first);
      exp_t e;
      int   base, stall_n, done_n, err_n, exp_err_n, first_c, lat_at_stall;
      logic prev_v;
      bit   fin;
      base = lat_total; stall_n = 0; done_n = 0; err_n = 0; exp_err_n = 0;
      first_c = -1; lat_at_stall = -1; prev_v = 1'b0; fin = 1'b0;
      for (int k = 0; k < 5; k++) begin
         e.addr = 23'(1 + int'(net) * 5 + k);
         e.data = ram_data(e.addr);
         e.idx  = 8'(k);
         e.err  = (e.data >= 16'd4);
         if (e.err) exp_err_n++;
         sbq.push_back(e);
      end
      netIndex = net;
      start = 1'b1;
      gif.geneReady = 1'b1;
      for (int c = 0; c < 400 && !fin; c++) begin
         @(negedge clk);
         start = b2b && (c == 2 || c == 6 || c == 10);
         netIndex = b2b ? 8'd7 : net;
         if (error) err_n++;
         if (done) begin done_n++; fin = 1'b1; end
         if (gif.geneValid) begin
            if (first_c < 0) first_c = c;
            if (sbq.size() == 0) chk("sb_underflow", 32'(sbq.size()), 32'd1);
            else begin
               e = sbq[0];
               if (!prev_v) begin
                  chk("ram_addr", 32'(lat_log[base + int'(e.idx)]), 32'(e.addr));
                  chk("gene_err", 32'(error), 32'(e.err));
               end
               chk("gene_data", 32'(gif.geneData), 32'(e.data));
               chk("gene_index", 32'(gif.geneIndex), 32'(e.idx));
               if (int'(e.idx) == stall_gene && stall_n < stall_cyc) begin
                  if (lat_at_stall < 0) lat_at_stall = lat_total;
                  gif.geneReady = 1'b0;
                  stall_n++;
               end else begin
                  if (int'(e.idx) == stall_gene) chk("stall_no_latch", 32'(lat_total), 32'(lat_at_stall));
                  gif.geneReady = 1'b1;
                  void'(sbq.pop_front());
               end
            end
         end
         prev_v = gif.geneValid;
      end
      if (!fin) chk("load_timeout", 32'(fin), 32'd1);
      start = 1'b0;
      repeat (4) begin
         @(negedge clk);
         if (done) done_n++;
         if (error) err_n++;
      end
      chk("done_count", 32'(done_n), 32'd1);
      chk("err_count", 32'(err_n), 32'(exp_err_n));
      chk("latch_count", 32'(lat_total - base), 32'd5);
      chk("sb_empty", 32'(sbq.size()), 32'd0);
      chk("busy_after", 32'(busy), 32'd0);
      if (exp_first >= 0) chk("first_latency", 32'(first_c + 1), 32'(exp_first));
      sbq.delete();
   endtask

   initial begin
      int base, done_n;
      bit found;
      rst_n = 1'b0; networkState = NS_LOAD; start = 1'b0; netIndex = '0;
      gif.geneReady = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_error", 32'(error), 32'd0);
      chk("rst_valid", 32'(gif.geneValid), 32'd0);
      chk("rst_data", 32'(gif.geneData), 32'd0);
      chk("rst_index", 32'(gif.geneIndex), 32'd0);
      chk("rst_latch", 32'(ramLatch), 32'd0);
      chk("rst_instr", 32'(ramInstruction), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Load network 3, addr=data: every word is out of range
      do_load(8'd3, -1, 0, 1'b0, 4);

      // Same network, small gene values, stall on gene 2, slower RAM
      ram_mode = 1'b1; ram_lat = 2;
      do_load(8'd3, 2, 3, 1'b0, -1);
      ram_mode = 1'b0; ram_lat = 0;

      // Out-of-range network index
      base = lat_total;
      start = 1'b1; netIndex = 8'd16;
      @(negedge clk);
      start = 1'b0;
      chk("badidx_error", 32'(error), 32'd1);
      chk("badidx_busy", 32'(busy), 32'd0);
      @(negedge clk);
      chk("badidx_error_pulse", 32'(error), 32'd0);
      repeat (3) @(negedge clk);
      chk("badidx_no_latch", 32'(lat_total - base), 32'd0);

      // Start outside the load phase
      networkState = NS_INIT;
      start = 1'b1; netIndex = 8'd2;
      @(negedge clk);
      start = 1'b0;
      chk("ns0_busy", 32'(busy), 32'd0);
      chk("ns0_error", 32'(error), 32'd0);
      chk("ns0_latch_z", 32'(ramLatch), 32'd1);
      chk("ns0_instr_z", 32'(ramInstruction), 32'd1);
      repeat (3) @(negedge clk);
      chk("ns0_busy_later", 32'(busy), 32'd0);
      chk("ns0_no_latch", 32'(lat_total - base), 32'd0);
      networkState = NS_LOAD;
      @(negedge clk);

      // Leave the load phase while gene 2 is presented
      found = 1'b0;
      gif.geneReady = 1'b1;
      start = 1'b1; netIndex = 8'd5;
      for (int c = 0; c < 200 && !found; c++) begin
         @(negedge clk);
         start = 1'b0;
         if (gif.geneValid && gif.geneIndex == 8'd2) begin
            gif.geneReady = 1'b0;
            networkState = NS_INIT;
            found = 1'b1;
            #1;
            chk("abort_latch_z", 32'(ramLatch), 32'd1);
            chk("abort_instr_z", 32'(ramInstruction), 32'd1);
         end
      end
      if (!found) chk("abort_timeout", 32'(found), 32'd1);
      @(negedge clk);
      chk("abort_valid", 32'(gif.geneValid), 32'd0);
      chk("abort_busy", 32'(busy), 32'd0);
      done_n = 0;
      repeat (10) begin
         @(negedge clk);
         if (done) done_n++;
      end
      chk("abort_no_done", 32'(done_n), 32'd0);
      networkState = NS_LOAD;
      @(negedge clk);

      // Reset while waiting for RAM data
      base = lat_total;
      ram_lat = 6;
      start = 1'b1; netIndex = 8'd0;
      repeat (5) begin
         @(negedge clk);
         start = 1'b0;
      end
      chk("rstmid_latched", 32'(lat_total - base), 32'd1);
      chk("rstmid_busy_before", 32'(busy), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("rstmid_busy", 32'(busy), 32'd0);
      chk("rstmid_valid", 32'(gif.geneValid), 32'd0);
      chk("rstmid_data", 32'(gif.geneData), 32'd0);
      chk("rstmid_index", 32'(gif.geneIndex), 32'd0);
      chk("rstmid_done", 32'(done), 32'd0);
      chk("rstmid_error", 32'(error), 32'd0);
      chk("rstmid_latch", 32'(ramLatch), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (10) @(negedge clk);
      ram_lat = 0;
      do_load(8'd0, -1, 0, 1'b0, 4);

      // Starts during a load are ignored
      ram_lat = 1;
      do_load(8'd9, -1, 0, 1'b1, -1);

      chk("latch_width", 32'(width_err), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
